// File: rtl/bus_master_if_pkg.sv
// Shared bus definitions for the core-side bus master: address/data widths,
// bus direction and active-low strobe levels, FSM state encoding and the
// latched command payload.
package bus_master_if_pkg;

    localparam int unsigned ADDR_W = 30;   // word address width
    localparam int unsigned DATA_W = 32;   // data width
    localparam int unsigned CNT_W  = 8;    // timeout counter width (TIMEOUT <= 255)

    // Bus direction
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    // Active-low strobe levels
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACCESS = 2'd2,
        ST_WAIT   = 2'd3
    } state_e;

    // Access captured from the core in IDLE
    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wr_data;
    } cmd_t;

endpackage

// File: rtl/bus_master_if_timeout.sv
// bus_timeout_cnt: WAIT-state timeout counter.
//   clk, reset : system clock, asynchronous active-high reset
//   clr_i      : clear count (asserted on the ACCESS->WAIT transition)
//   en_i       : count one WAIT cycle
//   tc_o       : registered terminal count; high during the TIMEOUT-th
//                consecutive WAIT cycle after a clear
module bus_timeout_cnt
    import bus_master_if_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    // Count value seen during the last WAIT cycle before abort
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tc_q;

    // Next count
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register; terminal flag is precomputed from the next count so it
    // lines up with cnt_q without a combinational compare on the output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= (cnt_d == TC_VAL);
        end
    end

    assign tc_o = tc_q;

endmodule

// File: rtl/bus_master_if.sv
// bus_master_if: converts single core accesses into arbitrated bus cycles
// (request, grant, one-cycle address strobe, ready/wait with timeout abort).
//   clk, reset         : system clock, asynchronous active-high reset
//   core_req/rw/addr/wr_data : access request from the core (sampled in IDLE)
//   core_rd_data       : last successfully read word
//   core_busy          : stall to core (combinational)
//   core_done/core_err : one-cycle completion pulse, err = timeout abort
//   bus_req_/bus_grnt_ : active-low arbiter handshake
//   bus_addr/bus_as_/bus_rw/bus_wr_data : registered bus command
//   bus_rd_data/bus_rdy_ : slave read data and active-low ready
module bus_master_if
    import bus_master_if_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_rw,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wr_data,
    output logic [DATA_W-1:0] core_rd_data,
    output logic              core_busy,
    output logic              core_done,
    output logic              core_err,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_
);

    state_e            state_q,       state_d;
    cmd_t              cmd_q,         cmd_d;
    logic              bus_req_q,     bus_req_d;
    logic              bus_as_q,      bus_as_d;
    logic              bus_rw_q,      bus_rw_d;
    logic [ADDR_W-1:0] bus_addr_q,    bus_addr_d;
    logic [DATA_W-1:0] bus_wr_data_q, bus_wr_data_d;
    logic [DATA_W-1:0] rd_data_q,     rd_data_d;
    logic              done_q,        done_d;
    logic              err_q,         err_d;

    logic cnt_clr;
    logic cnt_en;
    logic cnt_tc;

    bus_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        bus_req_d     = bus_req_q;
        bus_as_d      = DISABLE_;
        bus_rw_d      = bus_rw_q;
        bus_addr_d    = bus_addr_q;
        bus_wr_data_d = bus_wr_data_q;
        rd_data_d     = rd_data_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (core_req) begin
                    cmd_d.rw      = core_rw ? READ : WRITE;
                    cmd_d.addr    = core_addr;
                    cmd_d.wr_data = core_wr_data;
                    bus_req_d     = ENABLE_;
                    state_d       = ST_REQ;
                end
            end

            ST_REQ: begin
                if (bus_grnt_ == ENABLE_) begin
                    bus_as_d      = ENABLE_;
                    bus_rw_d      = cmd_q.rw;
                    bus_addr_d    = cmd_q.addr;
                    bus_wr_data_d = cmd_q.wr_data;
                    state_d       = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                if (bus_rdy_ == ENABLE_) begin
                    done_d    = 1'b1;
                    bus_req_d = DISABLE_;
                    state_d   = ST_IDLE;
                    if (cmd_q.rw == READ) begin
                        rd_data_d = bus_rd_data;
                    end
                end else begin
                    cnt_clr = 1'b1;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                cnt_en = 1'b1;
                // Ready wins over a coincident timeout
                if (bus_rdy_ == ENABLE_) begin
                    done_d    = 1'b1;
                    bus_req_d = DISABLE_;
                    state_d   = ST_IDLE;
                    if (cmd_q.rw == READ) begin
                        rd_data_d = bus_rd_data;
                    end
                end else if (cnt_tc) begin
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    bus_req_d = DISABLE_;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cmd_q         <= '0;
            bus_req_q     <= DISABLE_;
            bus_as_q      <= DISABLE_;
            bus_rw_q      <= READ;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
            rd_data_q     <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            bus_req_q     <= bus_req_d;
            bus_as_q      <= bus_as_d;
            bus_rw_q      <= bus_rw_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            rd_data_q     <= rd_data_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    // Busy is forced low while reset is asserted, whatever core_req does
    assign core_busy    = ~reset & ((state_q != ST_IDLE) | core_req);
    assign core_rd_data = rd_data_q;
    assign core_done    = done_q;
    assign core_err     = err_q;
    assign bus_req_     = bus_req_q;
    assign bus_as_      = bus_as_q;
    assign bus_rw       = bus_rw_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wr_data  = bus_wr_data_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Testbench for bus_master_if: directed scenarios plus randomized accesses
// checked against a cycle-count model of the access protocol.
module tb_bus_master_if;
    import bus_master_if_pkg::*;

    localparam int T      = 8;
    localparam int BUDGET = 60;
    localparam int NEVER  = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        core_req = 1'b0;
    logic        core_rw = 1'b0;
    logic [29:0] core_addr = '0;
    logic [31:0] core_wr_data = '0;
    logic [31:0] core_rd_data;
    logic        core_busy;
    logic        core_done;
    logic        core_err;
    logic        bus_req_;
    logic        bus_grnt_ = 1'b1;
    logic [29:0] bus_addr;
    logic        bus_as_;
    logic        bus_rw;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data = '0;
    logic        bus_rdy_ = 1'b1;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_rd = '0;

    bus_master_if #(.TIMEOUT(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .core_req     (core_req),
        .core_rw      (core_rw),
        .core_addr    (core_addr),
        .core_wr_data (core_wr_data),
        .core_rd_data (core_rd_data),
        .core_busy    (core_busy),
        .core_done    (core_done),
        .core_err     (core_err),
        .bus_req_     (bus_req_),
        .bus_grnt_    (bus_grnt_),
        .bus_addr     (bus_addr),
        .bus_as_      (bus_as_),
        .bus_rw       (bus_rw),
        .bus_wr_data  (bus_wr_data),
        .bus_rd_data  (bus_rd_data),
        .bus_rdy_     (bus_rdy_)
    );

    always #5 clk = ~clk;

    // Reference model: cycle 0 = core_req sampled in IDLE; grant arrives after
    // g REQ cycles without grant; ready arrives w cycles after the ACCESS cycle.
    function automatic int model_done(input int g, input int w);
        return g + 3 + ((w <= T) ? w : T);
    endfunction

    function automatic logic model_err(input int w);
        return (w > T);
    endfunction

    // Drives one access and acts as arbiter/slave; reports what it observed.
    task automatic run_txn(input logic rw, input logic [29:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int g, input int w, input bit noise,
                           output int done_cyc, output logic err, output logic [31:0] rd,
                           output int as_cnt, output int viol);
        int  req_low;
        int  acc_cyc;
        bit  acc_seen;
        bit  rdy_now;
        done_cyc = -1; err = 1'b0; rd = '0; as_cnt = 0; viol = 0;
        req_low = 0; acc_cyc = 0; acc_seen = 1'b0;
        @(negedge clk);
        core_req = 1'b1; core_rw = rw; core_addr = addr; core_wr_data = wdata;
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = $urandom;
        #1;
        if (core_busy !== 1'b1) viol++;
        for (int c = 1; c <= BUDGET; c++) begin
            @(negedge clk);
            if (bus_as_ === 1'b0) begin
                as_cnt++;
                if (!acc_seen) begin acc_seen = 1'b1; acc_cyc = c; end
            end
            if (acc_seen && (bus_addr !== addr || bus_rw !== rw || bus_wr_data !== wdata)) viol++;
            if (core_done === 1'b1) begin
                done_cyc = c; err = core_err; rd = core_rd_data;
                if (bus_req_ !== 1'b1) viol++;
                core_req = 1'b0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
                break;
            end
            if (bus_req_ !== 1'b0) viol++;
            if (core_busy !== 1'b1) viol++;
            if (bus_req_ === 1'b0) req_low++;
            if (acc_seen) bus_grnt_ = noise ? 1'($urandom) : 1'b0;
            else          bus_grnt_ = (req_low >= g + 1) ? 1'b0 : 1'b1;
            rdy_now     = acc_seen && (c - acc_cyc == w);
            bus_rdy_    = rdy_now ? 1'b0 : 1'b1;
            bus_rd_data = rdy_now ? rdata : $urandom;
            if (noise) begin
                core_req = 1'($urandom); core_rw = 1'($urandom);
                core_addr = 30'($urandom); core_wr_data = $urandom;
            end else begin
                core_req = 1'b0;
            end
        end
        core_req = 1'b0;
        if (done_cyc > 0) begin
            @(negedge clk);
            if (core_done !== 1'b0 || bus_req_ !== 1'b1 || bus_addr !== addr) viol++;
        end
    endtask

    task automatic test_reset();
        core_req = 1'b1;
        #1 reset = 1'b1;
        #2;
        n_checks++;
        if ({bus_req_, bus_as_, bus_rw, core_done, core_err, core_busy} !== 6'b111000)
            $display("FAIL reset_ctrl: got %b want 111000", {bus_req_, bus_as_, bus_rw, core_done, core_err, core_busy});
        else n_pass++;
        n_checks++;
        if (bus_addr !== 30'd0 || bus_wr_data !== 32'd0)
            $display("FAIL reset_bus: got addr=%h wdata=%h want 0", bus_addr, bus_wr_data);
        else n_pass++;
        n_checks++;
        if (core_rd_data !== 32'd0) $display("FAIL reset_rd: got %h want 0", core_rd_data);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++;
        if (core_busy !== 1'b0 || bus_req_ !== 1'b1)
            $display("FAIL reset_held: got busy=%b req_=%b want 0 1", core_busy, bus_req_);
        else n_pass++;
        core_req = 1'b0;
        reset = 1'b0;
        exp_rd = '0;
    endtask

    task automatic test_read_immediate();
        int d, a, v; logic e; logic [31:0] r;
        run_txn(READ, 30'h0000100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0, d, e, r, a, v);
        exp_rd = 32'hDEADBEEF;
        n_checks++; if (d !== 3) $display("FAIL rd_imm_latency: got %0d want 3", d); else n_pass++;
        n_checks++; if (e !== 1'b0) $display("FAIL rd_imm_err: got %b want 0", e); else n_pass++;
        n_checks++; if (r !== exp_rd) $display("FAIL rd_imm_data: got %h want %h", r, exp_rd); else n_pass++;
        n_checks++; if (a !== 1) $display("FAIL rd_imm_as_cycles: got %0d want 1", a); else n_pass++;
        n_checks++; if (v !== 0) $display("FAIL rd_imm_protocol: got %0d violations want 0", v); else n_pass++;
    endtask

    task automatic test_write_delayed();
        int d, a, v; logic e; logic [31:0] r;
        run_txn(WRITE, 30'h2AAAAAA, 32'h12345678, 32'hFFFF0000, 4, 2, 1'b0, d, e, r, a, v);
        n_checks++; if (d !== 9) $display("FAIL wr_latency: got %0d want 9", d); else n_pass++;
        n_checks++; if (e !== 1'b0) $display("FAIL wr_err: got %b want 0", e); else n_pass++;
        n_checks++; if (r !== exp_rd) $display("FAIL wr_rd_unchanged: got %h want %h", r, exp_rd); else n_pass++;
        n_checks++; if (a !== 1) $display("FAIL wr_as_cycles: got %0d want 1", a); else n_pass++;
        n_checks++; if (v !== 0) $display("FAIL wr_protocol: got %0d violations want 0", v); else n_pass++;
    endtask

    task automatic test_timeout();
        int d, a, v; logic e; logic [31:0] r;
        run_txn(READ, 30'h0001234, 32'h0, 32'h55555555, 0, NEVER, 1'b0, d, e, r, a, v);
        n_checks++; if (d !== 3 + T) $display("FAIL to_latency: got %0d want %0d", d, 3 + T); else n_pass++;
        n_checks++; if (e !== 1'b1) $display("FAIL to_err: got %b want 1", e); else n_pass++;
        n_checks++; if (r !== exp_rd) $display("FAIL to_rd_unchanged: got %h want %h", r, exp_rd); else n_pass++;
        n_checks++; if (v !== 0) $display("FAIL to_protocol: got %0d violations want 0", v); else n_pass++;
    endtask

    task automatic test_timeout_edge();
        int d, a, v; logic e; logic [31:0] r;
        run_txn(READ, 30'h0000040, 32'h0, 32'h0BADF00D, 1, T, 1'b0, d, e, r, a, v);
        exp_rd = 32'h0BADF00D;
        n_checks++; if (d !== 4 + T) $display("FAIL edge_latency: got %0d want %0d", d, 4 + T); else n_pass++;
        n_checks++; if (e !== 1'b0) $display("FAIL edge_err: got %b want 0", e); else n_pass++;
        n_checks++; if (r !== exp_rd) $display("FAIL edge_data: got %h want %h", r, exp_rd); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        int d, a, v, nd; logic e; logic [31:0] r;
        @(negedge clk);
        core_req = 1'b1; core_rw = READ; core_addr = 30'h3000000; core_wr_data = 32'h0;
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
        @(negedge clk); core_req = 1'b0; bus_grnt_ = 1'b0;  // REQ
        @(negedge clk);                                     // ACCESS, not ready
        @(negedge clk);                                     // WAIT 1
        @(negedge clk);                                     // WAIT 2
        core_req = 1'b1;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({bus_req_, bus_as_, bus_rw, core_done, core_err, core_busy} !== 6'b111000)
            $display("FAIL mid_reset_ctrl: got %b want 111000", {bus_req_, bus_as_, bus_rw, core_done, core_err, core_busy});
        else n_pass++;
        n_checks++;
        if (bus_addr !== 30'd0 || bus_wr_data !== 32'd0 || core_rd_data !== 32'd0)
            $display("FAIL mid_reset_data: got addr=%h wdata=%h rd=%h want 0", bus_addr, bus_wr_data, core_rd_data);
        else n_pass++;
        nd = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (core_done !== 1'b0) nd++;
        end
        core_req = 1'b0; bus_grnt_ = 1'b1;
        reset = 1'b0;
        exp_rd = '0;
        n_checks++; if (nd !== 0) $display("FAIL mid_reset_no_done: got %0d pulses want 0", nd); else n_pass++;
        run_txn(READ, 30'h0000200, 32'h0, 32'hA5A5A5A5, 0, 1, 1'b0, d, e, r, a, v);
        exp_rd = 32'hA5A5A5A5;
        n_checks++; if (d !== 4) $display("FAIL post_reset_latency: got %0d want 4", d); else n_pass++;
        n_checks++; if (r !== exp_rd || e !== 1'b0) $display("FAIL post_reset_read: got %h err=%b want %h err=0", r, e, exp_rd); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int nd, d1, d2, relow; logic req_d1, busy_d1; logic [31:0] rd1, rd2;
        logic [31:0] da, db;
        bit rdy_now;
        da = 32'h11111111; db = 32'h22222222;
        nd = 0; d1 = -1; d2 = -1; relow = -1; req_d1 = 1'b0; busy_d1 = 1'b0; rd1 = '0; rd2 = '0;
        @(negedge clk);
        core_req = 1'b1; core_rw = READ; core_addr = 30'h0000010;
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (d1 > 0 && relow < 0 && bus_req_ === 1'b0) relow = c;
            if (core_done === 1'b1) begin
                nd++;
                if (nd == 1) begin d1 = c; rd1 = core_rd_data; req_d1 = bus_req_; busy_d1 = core_busy; end
                else begin d2 = c; rd2 = core_rd_data; core_req = 1'b0; end
            end
            if (nd == 2) break;
            bus_grnt_   = (bus_req_ === 1'b0) ? 1'b0 : 1'b1;
            rdy_now     = (bus_as_ === 1'b0);
            bus_rdy_    = rdy_now ? 1'b0 : 1'b1;
            bus_rd_data = rdy_now ? ((nd == 0) ? da : db) : $urandom;
        end
        core_req = 1'b0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
        exp_rd = db;
        n_checks++; if (d1 !== 3) $display("FAIL b2b_first_done: got %0d want 3", d1); else n_pass++;
        n_checks++; if (req_d1 !== 1'b1 || busy_d1 !== 1'b1) $display("FAIL b2b_idle_cycle: got req_=%b busy=%b want 1 1", req_d1, busy_d1); else n_pass++;
        n_checks++; if (relow !== 4) $display("FAIL b2b_next_req: got %0d want 4", relow); else n_pass++;
        n_checks++; if (d2 !== 6) $display("FAIL b2b_second_done: got %0d want 6", d2); else n_pass++;
        n_checks++; if (rd1 !== da || rd2 !== db) $display("FAIL b2b_data: got %h %h want %h %h", rd1, rd2, da, db); else n_pass++;
        @(negedge clk);
        n_checks++; if (core_done !== 1'b0 || bus_req_ !== 1'b1) $display("FAIL b2b_stop: got done=%b req_=%b want 0 1", core_done, bus_req_); else n_pass++;
    endtask

    task automatic test_random();
        int d, a, v, g, w, ed; logic e, ee, rw; logic [31:0] r, wd, rdat; logic [29:0] ad;
        for (int i = 0; i < 25; i++) begin
            rw = 1'($urandom); ad = 30'($urandom); wd = $urandom; rdat = $urandom;
            g = int'($urandom_range(0, 5));
            w = (i % 5 == 0) ? T : int'($urandom_range(0, 10));
            run_txn(rw, ad, wd, rdat, g, w, 1'b1, d, e, r, a, v);
            ed = model_done(g, w);
            ee = model_err(w);
            if (rw == READ && !ee) exp_rd = rdat;
            n_checks++; if (d !== ed) $display("FAIL rand%0d_latency: got %0d want %0d", i, d, ed); else n_pass++;
            n_checks++; if (e !== ee) $display("FAIL rand%0d_err: got %b want %b", i, e, ee); else n_pass++;
            n_checks++; if (r !== exp_rd) $display("FAIL rand%0d_rd: got %h want %h", i, r, exp_rd); else n_pass++;
            n_checks++; if (a !== 1) $display("FAIL rand%0d_as_cycles: got %0d want 1", i, a); else n_pass++;
            n_checks++; if (v !== 0) $display("FAIL rand%0d_protocol: got %0d violations want 0", i, v); else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_immediate();
        test_write_delayed();
        test_timeout();
        test_timeout_edge();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
